// File: rtl/snake_pkg.sv
// Shared constants, direction encoding and FSM states for the snake body
// streamer. Build with SNAKE_WRAP_EN defined to wrap at field edges.
package snake_pkg;

  localparam int H_LOGIC_WIDTH = 5;
  localparam int V_LOGIC_WIDTH = 5;
  localparam int H_LOGIC_MAX   = 31;
  localparam int V_LOGIC_MAX   = 23;
  localparam int MAX_LEN       = 201;
  localparam int INIT_X        = 2;
  localparam int INIT_Y        = 0;

  localparam int PTR_W = 8;
  localparam int LEN_W = 10;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef struct packed {
    logic [H_LOGIC_WIDTH-1:0] x;
    logic [V_LOGIC_WIDTH-1:0] y;
  } cell_t;

  localparam logic [H_LOGIC_WIDTH-1:0] X_MAX =
    H_LOGIC_WIDTH'(H_LOGIC_MAX);
  localparam logic [V_LOGIC_WIDTH-1:0] Y_MAX =
    V_LOGIC_WIDTH'(V_LOGIC_MAX);
  localparam len_t LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(MAX_LEN);

  localparam cell_t INIT_CELL = '{
    x: H_LOGIC_WIDTH'(INIT_X),
    y: V_LOGIC_WIDTH'(INIT_Y)
  };

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    FRAME,
    SEG_A,
    SEG_B,
    DONE
  } state_e;

  function automatic dir_e reverse_dir(input dir_e d);
    dir_e r;
    unique case (d)
      DIR_RIGHT: r = DIR_LEFT;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_UP:    r = DIR_DOWN;
      default:   r = DIR_UP;
    endcase
    return r;
  endfunction

  // Depth is not a power of two, so wrap explicitly.
  function automatic ptr_t ptr_add(input ptr_t a, input ptr_t b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH)
      s = s - DEPTH;
    return s[PTR_W-1:0];
  endfunction

  function automatic ptr_t ptr_dec(input ptr_t a);
    return (a == '0) ? ptr_t'(MAX_LEN - 1) : a - 1'b1;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next-head calculator: reversal filter plus wall or wrap handling.
// Edge behaviour selected by SNAKE_WRAP_EN.
module snake_next_head
  import snake_pkg::*;
(
  input  cell_t head,
  input  dir_e  dir_req,
  input  dir_e  cur_dir,
  input  len_t  length,
  output cell_t next,
  output logic  wall_hit,
  output dir_e  dir_eff
);

  always_comb begin
    dir_eff = dir_req;
    if (length > LEN_W'(1) && dir_req == reverse_dir(cur_dir))
      dir_eff = cur_dir;

    next     = head;
    wall_hit = 1'b0;
    unique case (1'b1)
      (dir_eff == DIR_RIGHT): begin
        if (head.x == X_MAX)
`ifdef SNAKE_WRAP_EN
          next.x = '0;
`else
          wall_hit = 1'b1;
`endif
        else
          next.x = head.x + 1'b1;
      end
      (dir_eff == DIR_LEFT): begin
        if (head.x == '0)
`ifdef SNAKE_WRAP_EN
          next.x = X_MAX;
`else
          wall_hit = 1'b1;
`endif
        else
          next.x = head.x - 1'b1;
      end
      (dir_eff == DIR_UP): begin
        if (head.y == '0)
`ifdef SNAKE_WRAP_EN
          next.y = Y_MAX;
`else
          wall_hit = 1'b1;
`endif
        else
          next.y = head.y - 1'b1;
      end
      default: begin
        if (head.y == Y_MAX)
`ifdef SNAKE_WRAP_EN
          next.y = '0;
`else
          wall_hit = 1'b1;
`endif
        else
          next.y = head.y + 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_streamer.sv
// Snake body ring buffer; moves on tick and streams segments head first.
// SNAKE_WRAP_EN (in snake_next_head) makes field edges wrap.
module snake_body_streamer
  import snake_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [1:0]               dir_in,
  input  logic                     is_eat,
  output logic [H_LOGIC_WIDTH-1:0] x_snake_cur,
  output logic [V_LOGIC_WIDTH-1:0] y_snake_cur,
  output logic [9:0]               length,
  output logic                     vld,
  output logic                     vld_start,
  output logic                     vld_t,
  output logic                     pixel_done,
  output logic                     is_end,
  output logic                     self_hit,
  output logic                     game_over
);

  state_e state;
  cell_t  body [MAX_LEN];
  ptr_t   head_ptr;
  ptr_t   k;
  cell_t  head;
  dir_e   cur_dir;
  logic   grow_pending;
  logic   tick_pending;
  logic   hit;

  cell_t  nxt;
  logic   wall;
  dir_e   dir_eff;
  ptr_t   new_ptr;
  ptr_t   seg_ptr;
  cell_t  seg;
  cell_t  cur;
  logic   last;

  snake_next_head u_next (
    .head     (head),
    .dir_req  (dir_e'(dir_in)),
    .cur_dir  (cur_dir),
    .length   (length),
    .next     (nxt),
    .wall_hit (wall),
    .dir_eff  (dir_eff)
  );

  // SEG_B preloads the following segment; FRAME loads the head.
  assign new_ptr = ptr_dec(head_ptr);
  assign seg_ptr = ptr_add(head_ptr,
                           (state == SEG_B) ? k + 1'b1 : '0);
  assign seg     = body[seg_ptr];
  assign cur     = {x_snake_cur, y_snake_cur};
  assign last    = ({2'b00, k} == length - 10'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      head_ptr     <= '0;
      body[0]      <= INIT_CELL;
      head         <= INIT_CELL;
      k            <= '0;
      length       <= 10'd1;
      x_snake_cur  <= INIT_CELL.x;
      y_snake_cur  <= INIT_CELL.y;
      vld          <= 1'b0;
      vld_start    <= 1'b0;
      vld_t        <= 1'b0;
      pixel_done   <= 1'b0;
      is_end       <= 1'b0;
      self_hit     <= 1'b0;
      game_over    <= 1'b0;
      grow_pending <= 1'b0;
      tick_pending <= 1'b0;
      cur_dir      <= DIR_RIGHT;
      hit          <= 1'b0;
    end else begin
      if (is_eat)
        grow_pending <= 1'b1;
      if (tick && state != IDLE && !game_over)
        tick_pending <= 1'b1;

      case (state)
        IDLE: begin
          if ((tick || tick_pending) && !game_over) begin
            tick_pending <= 1'b0;
            state        <= MOVE;
          end
        end
        MOVE: begin
          cur_dir <= dir_eff;
          if (wall) begin
            game_over <= 1'b1;
            state     <= IDLE;
          end else begin
            head_ptr      <= new_ptr;
            body[new_ptr] <= nxt;
            head          <= nxt;
            if (grow_pending && length < LEN_MAX)
              length <= length + 10'd1;
            // An eat arriving now belongs to the next move.
            grow_pending <= is_eat;
            k            <= '0;
            hit          <= 1'b0;
            vld          <= 1'b1;
            state        <= FRAME;
          end
        end
        FRAME: begin
          vld                        <= 1'b0;
          {x_snake_cur, y_snake_cur} <= seg;
          vld_start                  <= 1'b1;
          state                      <= SEG_A;
        end
        SEG_A: begin
          vld_start  <= 1'b0;
          vld_t      <= 1'b0;
          pixel_done <= 1'b1;
          is_end     <= last;
          if (k != '0 && cur == head)
            hit <= 1'b1;
          state <= SEG_B;
        end
        SEG_B: begin
          pixel_done <= 1'b0;
          is_end     <= 1'b0;
          if (last) begin
            state <= DONE;
          end else begin
            k                          <= k + 1'b1;
            {x_snake_cur, y_snake_cur} <= seg;
            vld_t                      <= 1'b1;
            state                      <= SEG_A;
          end
        end
        DONE: begin
          if (hit) begin
            self_hit  <= 1'b1;
            game_over <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_streamer.sv
// Self-checking bench for snake_body_streamer against a queue-based
// model of the snake; honours SNAKE_WRAP_EN like the design.
module tb_snake_body_streamer;

  localparam int HMAX = 31;
  localparam int VMAX = 23;
  localparam int MAXL = 201;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       is_eat = 1'b0;
  logic [4:0] x_snake_cur;
  logic [4:0] y_snake_cur;
  logic [9:0] length;
  logic       vld, vld_start, vld_t;
  logic       pixel_done, is_end;
  logic       self_hit, game_over;

  snake_body_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .dir_in      (dir_in),
    .is_eat      (is_eat),
    .x_snake_cur (x_snake_cur),
    .y_snake_cur (y_snake_cur),
    .length      (length),
    .vld         (vld),
    .vld_start   (vld_start),
    .vld_t       (vld_t),
    .pixel_done  (pixel_done),
    .is_end      (is_end),
    .self_hit    (self_hit),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model: body[0] is the head, each entry {x[4:0], y[4:0]}.
  logic [9:0] body[$];
  int         m_dir;
  bit         m_grow;
  bit         m_go;
  bit         m_self;

  task automatic m_reset();
    body.delete();
    body.push_back({5'd2, 5'd0});
    m_dir  = 0;
    m_grow = 0;
    m_go   = 0;
    m_self = 0;
  endtask

  task automatic m_move(input int d, output bit streamed);
    int eff, x, y;
    streamed = 0;
    if (m_go) return;
    eff = d;
    if (body.size() > 1 && d / 2 == m_dir / 2 && d != m_dir)
      eff = m_dir;
    m_dir = eff;
    x = int'(body[0][9:5]);
    y = int'(body[0][4:0]);
    case (eff)
      0: x = x + 1;
      1: x = x - 1;
      2: y = y - 1;
      default: y = y + 1;
    endcase
    if (x < 0 || x > HMAX || y < 0 || y > VMAX) begin
`ifdef SNAKE_WRAP_EN
      x = (x + HMAX + 1) % (HMAX + 1);
      y = (y + VMAX + 1) % (VMAX + 1);
`else
      m_go = 1;
      return;
`endif
    end
    body.push_front({x[4:0], y[4:0]});
    if (!(m_grow && body.size() <= MAXL))
      void'(body.pop_back());
    m_grow   = 0;
    streamed = 1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_reset();
  endtask

  task automatic collect(input bit pend);
    int L;
    L = body.size();
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      nchk++;
      if (vld !== (n == 2)) begin
        nerr++;
        $display("FAIL vld n=%0d got %b want %b", n, vld, n == 2);
      end
      if (pend && n == 2) tick = 1'b1;
    end
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      tick = 1'b0;
      nchk++;
      if (vld_start !== (k == 0) || vld_t !== (k != 0) ||
          {x_snake_cur, y_snake_cur} !== body[k]) begin
        nerr++;
        $display("FAIL seg_a k=%0d got %b%b (%0d,%0d) want (%0d,%0d)",
                 k, vld_start, vld_t, x_snake_cur, y_snake_cur,
                 body[k][9:5], body[k][4:0]);
      end
      @(negedge clk);
      nchk++;
      if (pixel_done !== 1'b1 || is_end !== (k == L - 1) ||
          vld_start !== 1'b0 || vld_t !== 1'b0 ||
          {x_snake_cur, y_snake_cur} !== body[k]) begin
        nerr++;
        $display("FAIL seg_b k=%0d got pd=%b end=%b xy=%h want end=%b xy=%h",
                 k, pixel_done, is_end, {x_snake_cur, y_snake_cur},
                 k == L - 1, body[k]);
      end
    end
    repeat (2) @(negedge clk);
    for (int k = 1; k < L; k++)
      if (body[k] == body[0]) begin
        m_go   = 1;
        m_self = 1;
      end
    nchk++;
    if (length !== L[9:0]) begin
      nerr++;
      $display("FAIL length got %0d want %0d", length, L);
    end
    nchk++;
    if (self_hit !== m_self || game_over !== m_go) begin
      nerr++;
      $display("FAIL flags got hit=%b go=%b want hit=%b go=%b",
               self_hit, game_over, m_self, m_go);
    end
  endtask

  task automatic no_stream();
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      nchk++;
      if (vld !== 1'b0 || vld_start !== 1'b0) begin
        nerr++;
        $display("FAIL no_stream n=%0d got vld=%b vs=%b want 0",
                 n, vld, vld_start);
      end
    end
    nchk++;
    if (game_over !== 1'b1) begin
      nerr++;
      $display("FAIL game_over got %b want 1", game_over);
    end
  endtask

  task automatic run_move(input int d, input bit eat, input bit pend);
    bit s;
    if (eat) begin
      is_eat = 1'b1;
      @(posedge clk);
      #1 is_eat = 1'b0;
      m_grow = 1;
    end
    dir_in = d[1:0];
    tick   = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    m_move(d, s);
    if (!s) begin
      no_stream();
      return;
    end
    collect(pend);
    if (pend) begin
      m_move(d, s);
      if (s) collect(1'b0);
      else   no_stream();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    nchk++;
    if (x_snake_cur !== 5'd2 || y_snake_cur !== 5'd0 ||
        length !== 10'd1) begin
      nerr++;
      $display("FAIL reset_xy got (%0d,%0d) len %0d want (2,0) len 1",
               x_snake_cur, y_snake_cur, length);
    end
    nchk++;
    if ({vld, vld_start, vld_t, pixel_done, is_end,
         self_hit, game_over} !== 7'd0) begin
      nerr++;
      $display("FAIL reset_flags got %b want 0",
               {vld, vld_start, vld_t, pixel_done, is_end,
                self_hit, game_over});
    end
  endtask

  task automatic test_single_move();
    do_reset();
    run_move(0, 0, 0);
  endtask

  task automatic test_grow();
    do_reset();
    run_move(0, 0, 0);
    run_move(0, 1, 0);
  endtask

  task automatic test_wall();
    do_reset();
    for (int i = 0; i < 29; i++) run_move(0, 0, 0);
    run_move(0, 0, 0);
`ifndef SNAKE_WRAP_EN
    nchk++;
    if (x_snake_cur !== 5'd31 || y_snake_cur !== 5'd0) begin
      nerr++;
      $display("FAIL wall_hold got (%0d,%0d) want (31,0)",
               x_snake_cur, y_snake_cur);
    end
`endif
  endtask

  task automatic test_reversal_selfhit();
    do_reset();
    run_move(0, 1, 0);
    run_move(1, 0, 0);
    run_move(3, 1, 0);
    run_move(0, 1, 0);
    run_move(2, 1, 0);
    run_move(1, 0, 0);
    nchk++;
    if (self_hit !== 1'b1 || game_over !== 1'b1) begin
      nerr++;
      $display("FAIL self_hit got %b/%b want 1/1", self_hit, game_over);
    end
    run_move(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_move(3, 1, 1);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    is_eat = 1'b1;
    @(posedge clk);
    #1 is_eat = 1'b0;
    dir_in = 2'd0;
    tick   = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (6) @(negedge clk);
    nchk++;
    if (pixel_done !== 1'b1 || is_end !== 1'b1) begin
      nerr++;
      $display("FAIL mid_segb got pd=%b end=%b want 1/1",
               pixel_done, is_end);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    nchk++;
    if ({vld, vld_start, vld_t, pixel_done, is_end} !== 5'd0 ||
        length !== 10'd1 || x_snake_cur !== 5'd2 ||
        y_snake_cur !== 5'd0) begin
      nerr++;
      $display("FAIL mid_reset got %b len %0d (%0d,%0d) want 0 1 (2,0)",
               {vld, vld_start, vld_t, pixel_done, is_end},
               length, x_snake_cur, y_snake_cur);
    end
    rst = 1'b1;
    m_reset();
    run_move(0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      run_move($urandom_range(3, 0), ($urandom_range(2, 0) == 0),
               ($urandom_range(4, 0) == 0));
      if (m_go) do_reset();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m_reset();
    test_reset();
    test_single_move();
    test_grow();
    test_wall();
    test_reversal_selfhit();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/snake_body_streamer.md
Name: snake_body_streamer

Overview:
Upstream neighbour of the apple/collision stage. Owns the snake body as a circular buffer of logical cell coordinates and advances the head one cell per move tick. It grows the snake when the downstream stage reports an eat. After every move it streams all segments, head first, using the vld / vld_start / vld_t / pixel_done / is_end handshake that the apple stage consumes.

Parameters:
H_LOGIC_WIDTH, 5, x coordinate width
V_LOGIC_WIDTH, 5, y coordinate width
H_LOGIC_MAX, 31, largest legal x
V_LOGIC_MAX, 23, largest legal y
MAX_LEN, 201, body buffer depth (segments)
INIT_X, 2, head x after reset
INIT_Y, 0, head y after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
tick  in  1  move request, 1-cycle pulse
dir_in  in  2  requested direction: 0 right(x+1), 1 left(x-1), 2 up(y-1), 3 down(y+1)
is_eat  in  1  eat report from apple stage
x_snake_cur  out  H_LOGIC_WIDTH  streamed segment x
y_snake_cur  out  V_LOGIC_WIDTH  streamed segment y
length  out  10  current segment count
vld  out  1  frame-start pulse, precedes each stream
vld_start  out  1  strobe, segment 0 valid
vld_t  out  1  strobe, segment k>0 valid
pixel_done  out  1  segment consumed, advance index
is_end  out  1  high with pixel_done of last segment
self_hit  out  1  sticky: head overlapped a body segment
game_over  out  1  sticky: self_hit or wall hit

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, port rst; clk and rst keep the codebase's port names.
- Reset (rst==0 at posedge), from any state including mid-stream:
  - state IDLE; length=1; buffer[head_ptr]=(INIT_X,INIT_Y).
  - x_snake_cur=INIT_X, y_snake_cur=INIT_Y.
  - vld, vld_start, vld_t, pixel_done, is_end, self_hit, game_over all 0.
  - grow_pending=0, tick_pending=0, cur_dir=0.
- All outputs are registered.
- FSM states: IDLE, MOVE, FRAME, SEG_A, SEG_B, DONE.
  - IDLE: on (tick or tick_pending) and !game_over go to MOVE, clearing tick_pending.
  - MOVE (1 cycle):
    - Latch dir_in into cur_dir, unless it is the 180° reversal of cur_dir with length>1; then keep cur_dir.
    - Compute the next head. On a wall hit, set game_over, return to IDLE, leave body unchanged, and produce no stream.
    - Otherwise: head_ptr = head_ptr-1 mod MAX_LEN and write the new head there.
    - If grow_pending and length<MAX_LEN: length+1. grow_pending is cleared either way; growth saturates at MAX_LEN.
  - FRAME (1 cycle): vld=1, k=0.
  - SEG_A: x/y = buffer[(head_ptr+k) mod MAX_LEN]. vld_start=1 if k==0, else vld_t=1.
  - SEG_B: x/y held, strobes 0, pixel_done=1, is_end=(k==length-1).
    - k<length-1: k+1 and go to SEG_A.
    - k==length-1: go to DONE.
  - DONE (1 cycle): if any segment k>=1 equals the head (compared during SEG_A), set self_hit and game_over. Then IDLE.
- Latency: tick sampled in IDLE at cycle t.
  - MOVE at t+1, vld at t+2, vld_start at t+3.
  - Last pixel_done/is_end at t+2+2*length; IDLE at t+4+2*length.
- tick outside IDLE sets tick_pending (one deep; further ticks dropped). Ticks are ignored while game_over=1.
- is_eat==1 in any cycle sets grow_pending. Simultaneous is_eat and MOVE: the MOVE consumes the old value, and the new eat stays pending.
- Index arithmetic is modulo MAX_LEN; there is no power-of-two assumption.

Optional Feature:
SNAKE_WRAP_EN.
- Defined: leaving the field wraps the head (x 31→0, 0→31; y 23→0, 0→23). A wall hit never occurs.
- Undefined: leaving the field is a wall hit, which sets game_over with no move and no stream.

Decomposition:
- Package snake_pkg holds:
  - width and max constants;
  - direction encoding (DIR_RIGHT..DIR_DOWN) and a reverse-direction function;
  - FSM state enum.
- Natural sub-module: snake_next_head, combinational. It takes head, dir and length and returns the next head, wall_hit and the effective direction, including the reversal filter and the wrap/wall rule.

Test Plan:
1. Reset low for 2 cycles, then high → x=2, y=0, length=1, all strobes 0, game_over=0.
2. tick with dir_in=0 at t → vld at t+2; vld_start with (3,0) at t+3; pixel_done and is_end at t+4; IDLE at t+6.
3. is_eat pulse, then tick right → length=2; stream (4,0) with vld_start, then (3,0) with vld_t; is_end on the 2nd pixel_done.
4. Head at (31,0), tick right → undefined: game_over=1, no vld, head stays (31,0). Defined: stream head (0,0).
5. length 2 moving right, dir_in=1 → reversal ignored, head moves to x+1. Grow to 5 and steer into the body → self_hit=1, game_over=1, later ticks ignored.
6. rst low during SEG_B of segment 1 → next cycle all strobes 0, length=1, (2,0) on x/y, state IDLE.
